// File: rtl/sensor_calib_ctrl.sv
// Delay-line sensor calibration: sweeps coarse/fine thermometer settings and
// stops at the first one whose averaged sensor popcount falls in the window.
module sensor_calib_ctrl #(
    parameter int COARSE_WIDTH  = 32,
    parameter int FINE_WIDTH    = 96,
    parameter int SENSOR_WIDTH  = 128,
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_n,
    input  logic                                start_i,
    input  logic                                abort_i,
    input  logic [$clog2(SENSOR_WIDTH+1)-1:0]   target_lo_i,
    input  logic [$clog2(SENSOR_WIDTH+1)-1:0]   target_hi_i,
    input  logic [SENSOR_WIDTH-1:0]             sensor_i,
    output logic [COARSE_WIDTH+FINE_WIDTH-1:0]  IDC_IDF_o,
    output logic                                IDC_IDF_en_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                fail_o,
    output logic [$clog2(SENSOR_WIDTH+1)-1:0]   avg_o
);

    localparam int LW    = $clog2(SENSOR_WIDTH + 1);
    localparam int ACC_W = LW + AVG_LOG2;
    localparam int CW    = $clog2(COARSE_WIDTH + 1);
    localparam int FW    = $clog2(FINE_WIDTH + 1);
    localparam int NSAMP = 1 << AVG_LOG2;
    localparam int TMAX  = (SETTLE_CYCLES > NSAMP) ? SETTLE_CYCLES : NSAMP;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [CW-1:0] C_MAX       = CW'(COARSE_WIDTH);
    localparam logic [FW-1:0] F_MAX       = FW'(FINE_WIDTH);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] SAMPLE_LAST = TW'(NSAMP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_DONE,
        S_FAIL
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  c_q, c_d;
    logic [FW-1:0]                  f_q, f_d;
    logic [TW-1:0]                  cnt_q, cnt_d;
    logic [ACC_W-1:0]               acc_q, acc_d;
    logic [LW-1:0]                  avg_q, avg_d;
    logic [LW-1:0]                  lo_q, lo_d;
    logic [LW-1:0]                  hi_q, hi_d;
    logic [COARSE_WIDTH+FINE_WIDTH-1:0] idc_q, idc_d;
    logic [SENSOR_WIDTH-1:0]        sensor_q;

    logic [LW-1:0] pop;
    logic [LW-1:0] avg_w;
    logic          busy;

    function automatic logic [COARSE_WIDTH-1:0] therm_c(input logic [CW-1:0] lvl);
        return ~({COARSE_WIDTH{1'b1}} << lvl);
    endfunction

    function automatic logic [FINE_WIDTH-1:0] therm_f(input logic [FW-1:0] lvl);
        return ~({FINE_WIDTH{1'b1}} << lvl);
    endfunction

    assign pop   = LW'($countones(sensor_q));
    assign avg_w = acc_q[ACC_W-1:AVG_LOG2];
    assign busy  = state_q inside {S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL};

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            f_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            avg_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            idc_q    <= '0;
            sensor_q <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            f_q      <= f_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            avg_q    <= avg_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            idc_q    <= idc_d;
            sensor_q <= sensor_i;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        avg_d   = avg_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        idc_d   = idc_q;
        if (abort_i && busy) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start_i) begin
                        lo_d = target_lo_i;
                        hi_d = target_hi_i;
                        c_d  = '0;
                        f_d  = '0;
                        if (target_lo_i > target_hi_i) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_LOAD;
                            idc_d   = '0;
                        end
                    end
                end
                S_LOAD: begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_SAMPLE;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                S_SAMPLE: begin
                    acc_d = acc_q + ACC_W'(pop);
                    if (cnt_q == SAMPLE_LAST) begin
                        state_d = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                S_EVAL: begin
                    avg_d = avg_w;
                    if (avg_w >= lo_q && avg_w <= hi_q) begin
                        state_d = S_DONE;
                    end else if (c_q == C_MAX && f_q == F_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        // fine is the inner loop; wrap it into the next coarse step
                        if (f_q == F_MAX) begin
                            f_d = '0;
                            c_d = c_q + CW'(1);
                        end else begin
                            f_d = f_q + FW'(1);
                        end
                        idc_d   = {therm_f(f_d), therm_c(c_d)};
                        state_d = S_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign IDC_IDF_o    = idc_q;
    assign IDC_IDF_en_o = (state_q == S_LOAD);
    assign busy_o       = busy;
    assign done_o       = (state_q == S_DONE);
    assign fail_o       = (state_q == S_FAIL);
    assign avg_o        = avg_q;

endmodule

// File: tb/tb_sensor_calib_ctrl.sv
// Directed bench for sensor_calib_ctrl: table of full sweeps plus
// hand-written abort, invalid-window and reset sequences.
module tb_sensor_calib_ctrl;

    localparam int M_ZERO = 0;
    localparam int M_HIT  = 1;
    localparam int M_ALT  = 2;
    localparam int M_ONES = 3;

    localparam logic [127:0] HIT_IDC = {96'h1F, 32'h3};
    localparam logic [127:0] S64     = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [127:0] S63     = {64'h0, 64'h7FFF_FFFF_FFFF_FFFF};

    typedef struct {
        int           mode;
        logic [7:0]   lo;
        logic [7:0]   hi;
        logic         exp_done;
        int           exp_lat;
        int           exp_strb;
        logic [127:0] exp_idc;
        logic [7:0]   exp_avg;
    } vec_t;

    vec_t vecs [5];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, abort;
    logic [7:0]   lo, hi;
    logic [127:0] sensor, idc;
    logic         en, busy, done, fail;
    logic [7:0]   avg;

    logic         start2;
    logic [4:0]   lo2, hi2;
    logic [15:0]  sensor2;
    logic [6:0]   idc2;
    logic         en2, busy2, done2, fail2;
    logic [4:0]   avg2;

    int   mode = M_ZERO;
    logic alt  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   strb = 0, strb2 = 0, dbl = 0;
    logic en_prev = 1'b0, en2_prev = 1'b0;

    always #5 clk = ~clk;

    sensor_calib_ctrl dut (
        .clk_i(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .target_lo_i(lo), .target_hi_i(hi), .sensor_i(sensor),
        .IDC_IDF_o(idc), .IDC_IDF_en_o(en), .busy_o(busy),
        .done_o(done), .fail_o(fail), .avg_o(avg)
    );

    sensor_calib_ctrl #(
        .COARSE_WIDTH(3), .FINE_WIDTH(4), .SENSOR_WIDTH(16),
        .SETTLE_CYCLES(2), .AVG_LOG2(1)
    ) dut_s (
        .clk_i(clk), .rst_n(rst_n), .start_i(start2), .abort_i(1'b0),
        .target_lo_i(lo2), .target_hi_i(hi2), .sensor_i(sensor2),
        .IDC_IDF_o(idc2), .IDC_IDF_en_o(en2), .busy_o(busy2),
        .done_o(done2), .fail_o(fail2), .avg_o(avg2)
    );

    assign sensor2 = '0;

    always_comb begin
        sensor = '0;
        if (mode == M_HIT && idc == HIT_IDC) sensor = S64;
        else if (mode == M_ALT) sensor = alt ? S63 : S64;
        else if (mode == M_ONES) sensor = '1;
    end

    always @(posedge clk) begin
        alt      <= ~alt;
        en_prev  <= en;
        en2_prev <= en2;
        if (en) strb <= strb + 1;
        if (en2) strb2 <= strb2 + 1;
        if ((en && en_prev) || (en2 && en2_prev)) dbl <= dbl + 1;
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        int n, base;
        mode = vecs[i].mode;
        lo   = vecs[i].lo;
        hi   = vecs[i].hi;
        @(negedge clk);
        base  = strb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_busy_load", i), 128'(busy), 128'd1);
        check($sformatf("v%0d_done_clr", i), 128'(done), 128'd0);
        n = 0;
        while (!(done || fail) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d_latency", i), 128'(n + 1), 128'(vecs[i].exp_lat));
        check($sformatf("v%0d_done", i), 128'(done), 128'(vecs[i].exp_done));
        check($sformatf("v%0d_fail", i), 128'(fail), 128'(!vecs[i].exp_done));
        check($sformatf("v%0d_busy", i), 128'(busy), 128'd0);
        check($sformatf("v%0d_strobes", i), 128'(strb - base), 128'(vecs[i].exp_strb));
        check($sformatf("v%0d_idc", i), idc, vecs[i].exp_idc);
        check($sformatf("v%0d_avg", i), 128'(avg), 128'(vecs[i].exp_avg));
    endtask

    initial begin
        int n, base;
        vecs[0] = '{M_HIT,  8'd60,  8'd70,  1'b1, 5201, 200, HIT_IDC, 8'd64};
        vecs[1] = '{M_HIT,  8'd64,  8'd64,  1'b1, 5201, 200, HIT_IDC, 8'd64};
        vecs[2] = '{M_ALT,  8'd63,  8'd63,  1'b1, 27,   1,   128'h0,  8'd63};
        vecs[3] = '{M_ONES, 8'd128, 8'd128, 1'b1, 27,   1,   128'h0,  8'd128};
        vecs[4] = '{M_ZERO, 8'd0,   8'd0,   1'b1, 27,   1,   128'h0,  8'd0};

        rst_n  = 1'b0;
        start  = 1'b1;
        abort  = 1'b0;
        start2 = 1'b1;
        lo = 8'd0; hi = 8'd0; lo2 = 5'd10; hi2 = 5'd20;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        check("rst_idc", idc, 128'h0);
        check("rst_en", 128'(en), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_fail", 128'(fail), 128'd0);
        check("rst_avg", 128'(avg), 128'd0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // exhaustion on the reduced instance: 4*5 settings, T=6
        @(negedge clk);
        base   = strb2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!(done2 || fail2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("exh_latency", 128'(n + 1), 128'd121);
        check("exh_fail", 128'(fail2), 128'd1);
        check("exh_done", 128'(done2), 128'd0);
        check("exh_busy", 128'(busy2), 128'd0);
        check("exh_strobes", 128'(strb2 - base), 128'd20);
        check("exh_idc", 128'(idc2), 128'h7F);
        check("exh_avg", 128'(avg2), 128'd0);

        // ignored start then abort; window 64..64 never hits with 63/64
        mode = M_ALT; lo = 8'd64; hi = 8'd64;
        @(negedge clk);
        base  = strb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (26) @(negedge clk);
        check("trunc_avg", 128'(avg), 128'd63);
        check("trunc_busy", 128'(busy), 128'd1);
        check("trunc_done", 128'(done), 128'd0);
        check("trunc_next_load", 128'(en), 128'd1);
        check("trunc_next_idc", idc, {96'h1, 32'h0});
        repeat (73) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", 128'(busy), 128'd1);
        repeat (199) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_fail", 128'(fail), 128'd0);
        check("abort_idc", idc, {96'h7FF, 32'h0});
        check("abort_strobes", 128'(strb - base), 128'd12);
        @(negedge clk);
        check("abort_idle", 128'(busy), 128'd0);
        check("abort_idc_hold", idc, {96'h7FF, 32'h0});

        // invalid window, then a valid restart from (0,0)
        lo = 8'd80; hi = 8'd40;
        @(negedge clk);
        base  = strb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("inv_fail", 128'(fail), 128'd1);
        check("inv_busy", 128'(busy), 128'd0);
        check("inv_done", 128'(done), 128'd0);
        repeat (5) @(negedge clk);
        check("inv_fail_hold", 128'(fail), 128'd1);
        check("inv_strobes", 128'(strb - base), 128'd0);
        check("inv_idc_hold", idc, {96'h7FF, 32'h0});
        mode = M_ZERO; lo = 8'd0; hi = 8'd5;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_fail_clr", 128'(fail), 128'd0);
        check("restart_busy", 128'(busy), 128'd1);
        check("restart_en", 128'(en), 128'd1);
        check("restart_idc", idc, 128'h0);
        n = 0;
        while (!(done || fail) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("restart_latency", 128'(n + 1), 128'd27);
        check("restart_done", 128'(done), 128'd1);

        // simultaneous start and abort during SETTLE
        mode = M_ALT; lo = 8'd64; hi = 8'd64;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("both_busy", 128'(busy), 128'd0);
        check("both_en", 128'(en), 128'd0);
        @(negedge clk);
        check("both_stay_idle", 128'(busy), 128'd0);
        check("both_no_load", 128'(en), 128'd0);

        // reset in the middle of a sweep
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_idc", idc, {96'h1, 32'h0});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_en", 128'(en), 128'd0);
        check("midrst_idc", idc, 128'h0);
        check("midrst_avg", 128'(avg), 128'd0);
        check("midrst_done", 128'(done), 128'd0);
        base = strb;
        repeat (40) @(negedge clk);
        check("midrst_strobes", 128'(strb - base), 128'd0);
        check("midrst_idle", 128'(busy), 128'd0);

        check("no_double_strobe", 128'(dbl), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
